// File: rtl/kal_div_pkg.sv
// Shared types and constants for the 32-bit signed AXI-Stream divider.
package kal_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] Q_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_NEG_SAT = 32'h8000_0000;
  localparam int unsigned       ITER_LAST = 0;

  // -2^31 maps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/kal_udiv_core.sv
// Unsigned restoring divider: load captures operands, each step retires one quotient bit (32 steps).
// No flow control of its own; the owning FSM decides when to load and step.
module kal_udiv_core
  import kal_div_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dvd_mag,
  input  logic [DATA_W-1:0] i_dvs_mag,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_last
);

  logic [DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // q_q starts as the dividend; its MSBs shift out into the remainder
  // while quotient bits shift in at the LSB.
  always_comb begin
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {p_q, q_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (i_load) begin
      p_d   = '0;
      q_d   = i_dvd_mag;
      dvs_d = i_dvs_mag;
      cnt_d = CNT_W'(DATA_W - 1);
    end else if (i_step) begin
      if (!diff[DATA_W]) begin
        p_d = diff[DATA_W-1:0];
        q_d = {q_q[DATA_W-2:0], 1'b1};
      end else begin
        p_d = shifted[DATA_W-1:0];
        q_d = {q_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      p_q   <= p_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_quo  = q_q;
  assign o_rem  = p_q;
  assign o_last = (cnt_q == CNT_W'(ITER_LAST));

endmodule

// File: rtl/kal_div32_axis.sv
// Signed 32-bit divider on AXI-Stream: fixed 33-clock accept-to-valid latency, one result per 35 clocks.
// Operands accepted only as a pair; result held bit-stable in DONE until i_dout_tready.
module kal_div32_axis
  import kal_div_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dividend_tvalid,
  output logic              o_dividend_tready,
  input  logic [DATA_W-1:0] i_dividend_tdata,
  input  logic              i_divisor_tvalid,
  output logic              o_divisor_tready,
  input  logic [DATA_W-1:0] i_divisor_tdata,
  output logic              o_dout_tvalid,
  input  logic              i_dout_tready,
  output logic [DATA_W-1:0] o_dout_tdata,
  output logic [DATA_W-1:0] o_dout_rem,
  output logic              o_dout_divzero,
  output logic              o_dout_ovf
);

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              odz_q, odz_d;
  logic              oovf_q, oovf_d;

  logic              accept;
  logic              core_load;
  logic              core_step;
  logic              core_last;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;

  assign accept = rdy_q & i_dividend_tvalid & i_divisor_tvalid;

  kal_udiv_core u_core (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (core_load),
    .i_step    (core_step),
    .i_dvd_mag (mag(i_dividend_tdata)),
    .i_dvs_mag (mag(i_divisor_tdata)),
    .o_quo     (core_quo),
    .o_rem     (core_rem),
    .o_last    (core_last)
  );

  always_comb begin
    state_d   = state_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    vld_d     = vld_q;
    dat_d     = dat_q;
    rem_d     = rem_q;
    odz_d     = odz_q;
    oovf_d    = oovf_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          q_neg_d   = i_dividend_tdata[DATA_W-1] ^ i_divisor_tdata[DATA_W-1];
          r_neg_d   = i_dividend_tdata[DATA_W-1];
          dz_d      = (i_divisor_tdata == '0);
          ovf_d     = (i_dividend_tdata == Q_NEG_SAT) && (i_divisor_tdata == '1);
          state_d   = CALC;
        end
      end
      CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor the core leaves |dividend| in the remainder,
        // so the signed remainder already equals the dividend.
        dat_d  = q_neg_q ? (~core_quo + 1'b1) : core_quo;
        rem_d  = r_neg_q ? (~core_rem + 1'b1) : core_rem;
        if (dz_q) begin
          dat_d = r_neg_q ? Q_NEG_SAT : Q_POS_SAT;
        end else if (ovf_q) begin
          dat_d = Q_POS_SAT;
        end
        odz_d   = dz_q;
        oovf_d  = ovf_q;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (i_dout_tready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      rem_q   <= '0;
      odz_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      odz_q   <= odz_d;
      oovf_q  <= oovf_d;
    end
  end

  assign o_dividend_tready = rdy_q;
  assign o_divisor_tready  = rdy_q;
  assign o_dout_tvalid     = vld_q;
  assign o_dout_tdata      = dat_q;
  assign o_dout_rem        = rem_q;
  assign o_dout_divzero    = odz_q;
  assign o_dout_ovf        = oovf_q;

endmodule

// File: tb/tb_kal_div32_axis.sv
// Directed bench for kal_div32_axis: vector table plus handshake, backpressure and reset sequences.
module tb_kal_div32_axis;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_dividend_tvalid;
  logic        o_dividend_tready;
  logic [31:0] i_dividend_tdata;
  logic        i_divisor_tvalid;
  logic        o_divisor_tready;
  logic [31:0] i_divisor_tdata;
  logic        o_dout_tvalid;
  logic        i_dout_tready;
  logic [31:0] o_dout_tdata;
  logic [31:0] o_dout_rem;
  logic        o_dout_divzero;
  logic        o_dout_ovf;

  int n_vec = 0;
  int n_err = 0;

  kal_div32_axis dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_dividend_tvalid (i_dividend_tvalid),
    .o_dividend_tready (o_dividend_tready),
    .i_dividend_tdata  (i_dividend_tdata),
    .i_divisor_tvalid  (i_divisor_tvalid),
    .o_divisor_tready  (o_divisor_tready),
    .i_divisor_tdata   (i_divisor_tdata),
    .o_dout_tvalid     (o_dout_tvalid),
    .i_dout_tready     (i_dout_tready),
    .o_dout_tdata      (o_dout_tdata),
    .o_dout_rem        (o_dout_rem),
    .o_dout_divzero    (o_dout_divzero),
    .o_dout_ovf        (o_dout_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " dividend_tready"}, 32'(o_dividend_tready), 32'd0);
    chk({nm, " divisor_tready"},  32'(o_divisor_tready),  32'd0);
    chk({nm, " tvalid"},          32'(o_dout_tvalid),     32'd0);
    chk({nm, " tdata"},           o_dout_tdata,           32'd0);
    chk({nm, " rem"},             o_dout_rem,             32'd0);
    chk({nm, " divzero"},         32'(o_dout_divzero),    32'd0);
    chk({nm, " ovf"},             32'(o_dout_ovf),        32'd0);
  endtask

  // Called #1 after the accept edge; returns clocks until tvalid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge i_clk);
      #1;
      lat++;
    end while (!o_dout_tvalid && lat < 100);
  endtask

  task automatic chk_result(input string nm, input int lat, input logic [31:0] eq,
                            input logic [31:0] er, input logic edz, input logic eovf);
    chk({nm, " latency"}, 32'(lat),               32'd33);
    chk({nm, " quo"},     o_dout_tdata,           eq);
    chk({nm, " rem"},     o_dout_rem,             er);
    chk({nm, " divzero"}, 32'(o_dout_divzero),    32'(edz));
    chk({nm, " ovf"},     32'(o_dout_ovf),        32'(eovf));
  endtask

  task automatic run_op(input string nm, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eovf);
    int lat;
    @(negedge i_clk);
    i_dividend_tdata  = dvd;
    i_divisor_tdata   = dvs;
    i_dividend_tvalid = 1'b1;
    i_divisor_tvalid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (o_dividend_tready && o_divisor_tready) break;
      @(negedge i_clk);
    end
    chk({nm, " ready before accept"}, 32'(o_dividend_tready & o_divisor_tready), 32'd1);
    @(posedge i_clk);
    #1;
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
    wait_result(lat);
    chk_result(nm, lat, eq, er, edz, eovf);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int lat;

    vecs[0]  = '{32'd819200000, 32'd200000,  32'd4096,      32'd0,         1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,       32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,         1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[4]  = '{32'd7,         32'd0,       32'h7FFFFFFF,  32'd7,         1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFF9,  32'd0,       32'h80000000,  32'hFFFFFFF9,  1'b1, 1'b0};
    vecs[6]  = '{32'd0,         32'd0,       32'h7FFFFFFF,  32'd0,         1'b1, 1'b0};
    vecs[7]  = '{32'h80000000,  32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,         1'b0, 1'b1};
    vecs[8]  = '{32'h80000000,  32'd1,       32'h80000000,  32'd0,         1'b0, 1'b0};
    vecs[9]  = '{32'd100,       32'd7,       32'd14,        32'd2,         1'b0, 1'b0};
    vecs[10] = '{32'h80000000,  32'd0,       32'h80000000,  32'h80000000,  1'b1, 1'b0};

    i_rst_n           = 1'b0;
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
    i_dividend_tdata  = '0;
    i_divisor_tdata   = '0;
    i_dout_tready     = 1'b1;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_idle_outputs("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready after reset release", 32'(o_dividend_tready & o_divisor_tready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].quo,
             vecs[i].rem, vecs[i].dz, vecs[i].ovf);
    end

    // Lone dividend valid must not be consumed; pair forms on cycle 6.
    i_dout_tready = 1'b0;
    @(negedge i_clk);
    i_dividend_tdata  = 32'd1000;
    i_divisor_tdata   = 32'd7;
    i_dividend_tvalid = 1'b1;
    i_divisor_tvalid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      chk($sformatf("lone valid cycle%0d ready", c), 32'(o_dividend_tready), 32'd1);
    end
    @(negedge i_clk);
    i_divisor_tvalid = 1'b1;
    @(posedge i_clk);
    #1;
    chk("pair accepted ready drop", 32'(o_dividend_tready | o_divisor_tready), 32'd0);
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
    wait_result(lat);
    chk_result("lone-then-pair", lat, 32'd142, 32'd6, 1'b0, 1'b0);

    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      #1;
      chk($sformatf("stall%0d tvalid", c), 32'(o_dout_tvalid), 32'd1);
      chk($sformatf("stall%0d quo", c), o_dout_tdata, 32'd142);
      chk($sformatf("stall%0d rem", c), o_dout_rem, 32'd6);
      chk($sformatf("stall%0d flags", c), {30'd0, o_dout_divzero, o_dout_ovf}, 32'd0);
      chk($sformatf("stall%0d treadys", c), 32'(o_dividend_tready | o_divisor_tready), 32'd0);
    end

    @(negedge i_clk);
    i_dout_tready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post handshake tvalid", 32'(o_dout_tvalid), 32'd0);
    chk("post handshake ready", 32'(o_dividend_tready & o_divisor_tready), 32'd1);
    @(negedge i_clk);
    i_dividend_tdata  = 32'hFFFFFFF9;
    i_divisor_tdata   = 32'd2;
    i_dividend_tvalid = 1'b1;
    i_divisor_tvalid  = 1'b1;
    @(posedge i_clk);
    #1;
    chk("back-to-back accept", 32'(o_dividend_tready | o_divisor_tready), 32'd0);
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
    wait_result(lat);
    chk_result("back-to-back", lat, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;

    // Reset during CALC discards the in-flight division.
    @(negedge i_clk);
    i_dividend_tdata  = 32'd12345;
    i_divisor_tdata   = 32'd67;
    i_dividend_tvalid = 1'b1;
    i_divisor_tvalid  = 1'b1;
    @(posedge i_clk);
    #1;
    chk("midcalc accept", 32'(o_dividend_tready), 32'd0);
    i_dividend_tvalid = 1'b0;
    i_divisor_tvalid  = 1'b0;
    repeat (15) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk_idle_outputs("midcalc reset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("after reset no stale tvalid", 32'(o_dout_tvalid), 32'd0);
    run_op("after reset 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kal_div32_axis.md
# kal_div32_axis

Sequential signed 32-bit divider acting as the AXI-Stream responder for the Kalman-gain stage of the gyro filter. It accepts a dividend/divisor pair on two slave channels and returns the truncated quotient and remainder on a master channel. It replaces the vendor divider core, so the gain is computed by in-house RTL with a fixed, deterministic latency the filter state machine can count against.

## Interface
- DATA_W, 32: operand/result width; only 32 is verified.
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  reset; one clock, reset asynchronous active-low
- i_dividend_tvalid  in  1  dividend valid
- o_dividend_tready  out  1  dividend accepted when valid&ready
- i_dividend_tdata  in  32  signed dividend
- i_divisor_tvalid  in  1  divisor valid
- o_divisor_tready  out  1  divisor accepted when valid&ready
- i_divisor_tdata  in  32  signed divisor
- o_dout_tvalid  out  1  result valid
- i_dout_tready  in  1  downstream ready; tie 1 if unused
- o_dout_tdata  out  32  signed quotient, truncated toward zero
- o_dout_rem  out  32  signed remainder, sign of dividend
- o_dout_divzero  out  1  divisor was 0, qualified by tvalid
- o_dout_ovf  out  1  -2^31 / -1 saturated, qualified by tvalid

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: both treadys = 1. Acceptance only when both tvalids are 1 in the same cycle. Pair captured; sign flags, |dividend|, |divisor|, divzero, ovf latched; 6-bit counter = 31; go CALC. A lone tvalid is never consumed.
- CALC: one restoring step per cycle on unsigned magnitudes with a 33-bit partial remainder. Shift in the next dividend MSB, trial-subtract divisor, set quotient bit if non-negative. Counter decrements; after the step at count 0, go FIX. Always 32 cycles, including divzero and ovf.
- FIX: apply signs. Quotient is negated if signs differ; remainder takes the dividend sign.
- Saturation is applied in FIX:
  - divzero: quotient = 0x7FFFFFFF if dividend >= 0, 0x80000000 if dividend < 0; remainder = dividend.
  - ovf (-2147483648 / -1): quotient = 0x7FFFFFFF, remainder = 0.
- FIX then goes to DONE.
- DONE: o_dout_tvalid = 1. tdata, rem and flags are held stable until i_dout_tready = 1. The handshake edge returns the block to IDLE.
- Both treadys are 0 in CALC, FIX and DONE. No input buffering.
- Magnitude of -2^31 is handled as unsigned 0x80000000; no overflow except the ovf case.

## Timing
- Reset values: o_dividend_tready = 0 and o_divisor_tready = 0 while i_rst_n = 0, then 1 from the first cycle after deassertion. o_dout_tvalid, o_dout_tdata, o_dout_rem, o_dout_divzero and o_dout_ovf are all 0.
- Accept edge E0. CALC occupies edges E1..E32, FIX is edge E33, and o_dout_tvalid is high in the cycle after E33. Latency is 33 clocks, constant for every operand pair.
- With i_dout_tready = 1: output handshake at E34, treadys high after E34, next accept at E35 at the earliest. Throughput is 1 result per 35 clocks.
- Backpressure: DONE is held indefinitely and outputs are bit-stable.
- Reset asserted mid-CALC or in DONE: immediate return to reset values. The in-flight result is discarded and never presented.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package kal_div_pkg holds:
  - DATA_W;
  - state enum {IDLE, CALC, FIX, DONE};
  - Q_POS_SAT = 32'h7FFFFFFF;
  - Q_NEG_SAT = 32'h80000000;
  - ITER_LAST = 0.
- One natural sub-module, kal_udiv_core: the unsigned shift/subtract datapath (partial remainder, quotient shift register, counter), driven by load/step strobes from the FSM in the top module.

## Test plan
- Kalman gain: dividend 819200000, divisor 200000 → quotient 4096, rem 0, flags 0, tvalid exactly 33 clocks after accept.
- Signs: -7 / 2 → -3, rem -1. 7 / -2 → -3, rem 1. -7 / -2 → 3, rem -1.
- Divide by zero:
  - 7 / 0 → 0x7FFFFFFF, divzero = 1.
  - -7 / 0 → 0x80000000, divzero = 1.
  - 0 / 0 → 0x7FFFFFFF, divzero = 1.
  - Latency is still 33 clocks in every case.
- Overflow and extremes:
  - -2147483648 / -1 → 0x7FFFFFFF, ovf = 1, rem 0.
  - -2147483648 / 1 → 0x80000000, flags 0.
- Handshake:
  - Dividend valid alone for 5 cycles, divisor valid at cycle 6 → accept only at cycle 6.
  - Hold i_dout_tready = 0 for 10 cycles → outputs stable, both treadys 0.
  - Release tready → next pair accepted 1 clock after the handshake.
- Reset: assert i_rst_n = 0 at CALC cycle 15 → all outputs 0 at once. After release, 100 / 7 → 14, rem 2, with no stale tvalid.
